// File: rtl/life_pkg.sv
// Shared types and constants for the life LED frame transmitter.
package life_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LATCH
  } tx_state_e;

  localparam logic       TRANSMIT_FRAME = 1'b0;
  localparam logic       IDLE           = 1'b1;
  localparam logic [7:0] DEAD           = 8'h00;
  localparam logic [7:0] ALIVE          = 8'hFF;
  localparam logic [5:0] MAX_PIXELS     = 6'd63;

  // Odd rows run right-to-left on zig-zag wired matrices.
  function automatic logic [5:0] pixel_addr(input logic [5:0] idx, input logic serpentine);
    return (serpentine && idx[3]) ? {idx[5:3], ~idx[2:0]} : idx;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Shapes one WS2812 bit: a bit_start pulse launches a BIT_CYCLES-long bit in the
// following cycle; bit_done marks its final cycle so the next bit can follow seamlessly.
module ws2812_bit_encoder #(
  parameter int BIT_CYCLES = 15,
  parameter int T0H_CYCLES = 4,
  parameter int T1H_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_value_i,
  input  logic bit_start_i,
  output logic led_out_o,
  output logic bit_done_o
);

  localparam int CW = $clog2(BIT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_q, bit_d;
  logic          active_q, active_d;
  logic          led_q, led_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      bit_q    <= 1'b0;
      active_q <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (bit_start_i) begin
      cnt_d    = '0;
      bit_d    = bit_value_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == CW'(BIT_CYCLES - 1)) active_d = 1'b0;
      else                              cnt_d    = cnt_q + 1'b1;
    end
    // The pin value is computed from next state so led_out stays a plain flop output.
    led_d = active_d && (int'(cnt_d) < (bit_d ? T1H_CYCLES : T0H_CYCLES));
  end

  assign led_out_o  = led_q;
  assign bit_done_o = active_q && (cnt_q == CW'(BIT_CYCLES - 1));

endmodule

// File: rtl/life_frame_tx.sv
// Streams one 8x8 life generation from pixel memory to a WS2812 chain.
// Define LIFE_FRAME_TX_SERPENTINE_EN to reverse the column order on odd rows.
module life_frame_tx
  import life_pkg::*;
#(
  parameter int         BIT_CYCLES   = 15,
  parameter int         T0H_CYCLES   = 4,
  parameter int         T1H_CYCLES   = 8,
  parameter int         LATCH_CYCLES = 960,
  parameter int         READ_LATENCY = 1,
  parameter logic [2:0] COLOR_MASK   = 3'b100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] address,
  input  logic [7:0] read_data,
  output logic       state,
  output logic       led_out,
  output logic       busy,
  output logic       frame_done
);

`ifdef LIFE_FRAME_TX_SERPENTINE_EN
  localparam logic SERPENTINE = 1'b1;
`else
  localparam logic SERPENTINE = 1'b0;
`endif

  localparam int CNT_MAX = ((BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES) - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_e        fsm_q, fsm_d;
  logic [5:0]       pix_q, pix_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [5:0]       address_q, address_d;
  logic             state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic        fetch_last, bit_done, last_bit, bit_start;
  logic [23:0] grb;

  assign fetch_last = (fsm_q == S_FETCH) && (cnt_q == CNT_W'(READ_LATENCY - 1));
  assign last_bit   = bit_done && (bit_idx_q == 5'd23);
  assign bit_start  = fetch_last || (bit_done && !last_bit);
  assign grb        = {COLOR_MASK[2] ? read_data : DEAD,
                       COLOR_MASK[1] ? read_data : DEAD,
                       COLOR_MASK[0] ? read_data : DEAD};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      pix_q     <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      address_q <= '0;
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      pix_q     <= pix_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      address_q <= address_d;
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    pix_d     = pix_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          fsm_d = S_FETCH;
          pix_d = '0;
          cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (fetch_last) begin
          fsm_d     = S_SHIFT;
          shreg_d   = grb;
          bit_idx_d = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          if (pix_q == MAX_PIXELS) begin
            fsm_d = S_LATCH;
          end else begin
            fsm_d = S_FETCH;
            pix_d = pix_q + 1'b1;
          end
        end else if (bit_done) begin
          bit_idx_d = bit_idx_q + 1'b1;
          shreg_d   = shreg_q << 1;
        end
      end
      S_LATCH: begin
        if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
          fsm_d = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from next state so they line up with the FSM.
  always_comb begin
    address_d = address_q;
    if (fsm_q != S_FETCH && fsm_d == S_FETCH) address_d = pixel_addr(pix_d, SERPENTINE);
    state_d = (fsm_d == S_IDLE) ? IDLE : TRANSMIT_FRAME;
    busy_d  = (fsm_d != S_IDLE);
    done_d  = (fsm_d == S_LATCH) && (cnt_d == CNT_W'(LATCH_CYCLES - 1));
  end

  ws2812_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_encoder (
    .clk         (clk),
    .rst         (rst),
    .bit_value_i (shreg_d[23]),
    .bit_start_i (bit_start),
    .led_out_o   (led_out),
    .bit_done_o  (bit_done)
  );

  assign address    = address_q;
  assign state      = state_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_life_frame_tx.sv
// Bench for life_frame_tx: two instances (READ_LATENCY 1 and 2) decoded by a scoreboard.
// Memory model: read_data reflects the address presented READ_LATENCY-1 clocks earlier.
module tb_life_frame_tx;

  localparam int         BIT   = 15;
  localparam int         T0H   = 4;
  localparam int         T1H   = 8;
  localparam int         LATCH = 960;
  localparam logic [2:0] MASK  = 3'b100;
  localparam int         LEN_A = 64 * (1 + 24 * BIT) + LATCH;
  localparam int         LEN_B = 64 * (2 + 24 * BIT) + LATCH;
  localparam int         TAIL  = (BIT - T0H) + LATCH;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] addr_a, addr_b, addr_b_d1;
  logic [7:0] rd_a, rd_b;
  logic       state_a, state_b, led_a, led_b, busy_a, busy_b, done_a, done_b;
  int         mode;

  int n_tests = 0;
  int n_fail  = 0;

  logic [29:0] exp_a[$];
  logic [29:0] exp_b[$];

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_addr(input int i);
    logic [5:0] p;
    p = 6'(i);
`ifdef LIFE_FRAME_TX_SERPENTINE_EN
    if (p[3]) p[2:0] = ~p[2:0];
`endif
    return p;
  endfunction

  function automatic logic [7:0] mem_a(input logic [5:0] a, input int m);
    if (m == 0) return 8'hFF;
    if (m == 1) return 8'h00;
    return {a, 2'b11};
  endfunction

  function automatic logic [7:0] mem_b(input logic [5:0] a);
    return (a == 6'd9) ? 8'hA5 : 8'h00;
  endfunction

  function automatic logic [23:0] to_grb(input logic [7:0] d);
    return {MASK[2] ? d : 8'h00, MASK[1] ? d : 8'h00, MASK[0] ? d : 8'h00};
  endfunction

  assign rd_a = mem_a(addr_a, mode);
  always @(posedge clk) addr_b_d1 <= addr_b;
  assign rd_b = mem_b(addr_b_d1);

  life_frame_tx u_dut_a (
    .clk(clk), .rst(rst), .start(start), .address(addr_a), .read_data(rd_a),
    .state(state_a), .led_out(led_a), .busy(busy_a), .frame_done(done_a)
  );

  life_frame_tx #(.READ_LATENCY(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .address(addr_b), .read_data(rd_b),
    .state(state_b), .led_out(led_b), .busy(busy_b), .frame_done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input int m);
    for (int i = 0; i < 64; i++) begin
      exp_a.push_back({exp_addr(i), to_grb(mem_a(exp_addr(i), m))});
      exp_b.push_back({exp_addr(i), to_grb(mem_b(exp_addr(i)))});
    end
  endtask

  // LED stream decoder and scoreboard consumer, one lane per instance.
  int          cyc = 0;
  int          hi_len[2], last_rise[2], nbits[2], flen[2], lowrun[2], ndone[2];
  logic [23:0] word[2];
  logic        prev_led[2], prev_done[2];

  always @(negedge clk) begin
    cyc++;
    for (int ch = 0; ch < 2; ch++) begin
      logic        led, st, bsy, dn, have;
      logic [5:0]  ad;
      logic [29:0] e;
      int          bi;
      led = (ch == 0) ? led_a   : led_b;
      st  = (ch == 0) ? state_a : state_b;
      bsy = (ch == 0) ? busy_a  : busy_b;
      dn  = (ch == 0) ? done_a  : done_b;
      ad  = (ch == 0) ? addr_a  : addr_b;
      if (rst) begin
        prev_led[ch]  = 1'b0;
        prev_done[ch] = 1'b0;
        nbits[ch]     = 0;
        hi_len[ch]    = 0;
        flen[ch]      = 0;
        lowrun[ch]    = 0;
      end else begin
        have = (ch == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0);
        e    = '0;
        if (have) e = (ch == 0) ? exp_a[0] : exp_b[0];
        if (prev_done[ch]) check("idle_after_done", 32'(st), 32'(1));
        check("busy_vs_state", 32'(bsy), 32'(!st));
        if (led && !prev_led[ch]) begin
          if (nbits[ch] > 0) check("bit_period", 32'(cyc - last_rise[ch]), 32'(BIT));
          last_rise[ch] = cyc;
          hi_len[ch]    = 0;
        end
        if (led) hi_len[ch]++;
        if (!led && prev_led[ch]) begin
          bi = 23 - nbits[ch];
          if (have) check("pulse_high", 32'(hi_len[ch]), 32'(e[bi] ? T1H : T0H));
          word[ch] = {word[ch][22:0], (hi_len[ch] > (T0H + T1H) / 2)};
          nbits[ch]++;
          if (nbits[ch] == 24) begin
            nbits[ch] = 0;
            check("sb_nonempty", 32'(have), 32'(1));
            if (have) begin
              check("pixel_grb", 32'(word[ch]), 32'(e[23:0]));
              check("pixel_addr", 32'(ad), 32'(e[29:24]));
              if (ch == 0) void'(exp_a.pop_front());
              else         void'(exp_b.pop_front());
            end
          end
        end
        if (!st) flen[ch]++;
        lowrun[ch] = (!led && !st) ? lowrun[ch] + 1 : 0;
        if (dn) begin
          ndone[ch]++;
          check("frame_len", 32'(flen[ch]), 32'((ch == 0) ? LEN_A : LEN_B));
          check("latch_low", 32'(lowrun[ch]), 32'(TAIL));
          flen[ch] = 0;
        end
        prev_done[ch] = dn;
        prev_led[ch]  = led;
      end
    end
  end

  int k;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    ndone[0] = 0;
    ndone[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_a", 32'(addr_a), 32'(0));
    check("rst_led_a", 32'(led_a), 32'(0));
    check("rst_state_a", 32'(state_a), 32'(1));
    check("rst_busy_a", 32'(busy_a), 32'(0));
    check("rst_done_a", 32'(done_a), 32'(0));
    check("rst_addr_b", 32'(addr_b), 32'(0));
    check("rst_state_b", 32'(state_b), 32'(1));
    @(negedge clk);
    rst = 1'b0;

    // Frame 1: all pixels alive, start re-pulsed mid-frame and on the frame_done cycle.
    @(posedge clk); #1;
    push_frame(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_fetch_state", 32'(state_a), 32'(0));
    check("first_fetch_addr", 32'(addr_a), 32'(exp_addr(0)));
    k = 1;
    while (k < 30000) begin
      start = (k == 100 || k == LEN_A);
      if (done_a) break;
      @(posedge clk); #1;
      k++;
    end
    check("done_cycle_a", 32'(k), 32'(LEN_A));
    @(posedge clk); #1;
    start = 1'b0;
    k++;
    check("state_idle_a", 32'(state_a), 32'(1));
    while (!done_b && k < 30000) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_cycle_b", 32'(k), 32'(LEN_B));
    repeat (300) @(posedge clk);
    #1;
    check("no_restart_a", 32'(state_a), 32'(1));
    check("no_restart_b", 32'(state_b), 32'(1));
    check("done_once_a", 32'(ndone[0]), 32'(1));
    check("done_once_b", 32'(ndone[1]), 32'(1));
    check("addr_hold_a", 32'(addr_a), 32'(exp_addr(63)));
    check("sb_drained_a", 32'(exp_a.size()), 32'(0));
    check("sb_drained_b", 32'(exp_b.size()), 32'(0));

    // Frame 2: address-dependent data, cut by a reset mid-bit while led_out is high.
    mode = 2;
    push_frame(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (!(k >= 5000 && led_a) && k < 10000) begin
      @(posedge clk); #1;
      k++;
    end
    check("reset_point_led_high", 32'(led_a), 32'(1));
    rst = 1'b1;
    #1;
    check("async_led_a", 32'(led_a), 32'(0));
    check("async_busy_a", 32'(busy_a), 32'(0));
    check("async_addr_a", 32'(addr_a), 32'(0));
    check("async_state_a", 32'(state_a), 32'(1));
    check("async_busy_b", 32'(busy_b), 32'(0));
    check("async_addr_b", 32'(addr_b), 32'(0));
    exp_a.delete();
    exp_b.delete();
    ndone[0] = 0;
    ndone[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Frame 3: all pixels dead, full frame after reset.
    mode = 1;
    @(posedge clk); #1;
    push_frame(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_addr_a", 32'(addr_a), 32'(exp_addr(0)));
    k = 1;
    while (!(done_a && done_b) && !done_b && k < 30000) begin
      @(posedge clk); #1;
      k++;
    end
    check("dead_frame_len_b", 32'(k), 32'(LEN_B));
    repeat (50) @(posedge clk);
    #1;
    check("dead_done_a", 32'(ndone[0]), 32'(1));
    check("dead_done_b", 32'(ndone[1]), 32'(1));
    check("dead_drained_a", 32'(exp_a.size()), 32'(0));
    check("dead_drained_b", 32'(exp_b.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
